// File: rtl/key_conditioner_if.sv
// key_conditioner_if: pushbutton bus between the raw DE2 keys and the conditioner.
//   KEY         raw active-low pushbuttons (0 = pressed), asynchronous
//   KEY_LEVEL   debounced level, 1 = pressed
//   KEY_PRESS   one-cycle pulse on accepted press (and auto-repeat)
//   KEY_RELEASE one-cycle pulse on accepted release
//   KEY_TOGGLE  latch inverted on every accepted press
// master: drives KEY (board / bench side); slave: the conditioner.
interface key_conditioner_if #(
    parameter int unsigned N_KEYS = 4
);
    logic [N_KEYS-1:0] KEY;
    logic [N_KEYS-1:0] KEY_LEVEL;
    logic [N_KEYS-1:0] KEY_PRESS;
    logic [N_KEYS-1:0] KEY_RELEASE;
    logic [N_KEYS-1:0] KEY_TOGGLE;

    modport master (
        output KEY,
        input  KEY_LEVEL,
        input  KEY_PRESS,
        input  KEY_RELEASE,
        input  KEY_TOGGLE
    );

    modport slave (
        input  KEY,
        output KEY_LEVEL,
        output KEY_PRESS,
        output KEY_RELEASE,
        output KEY_TOGGLE
    );
endinterface

// File: rtl/key_conditioner.sv
// key_conditioner: synchronises and debounces the active-low DE2 pushbuttons.
// Each key gets a 2-flop synchroniser, a four-state debounce FSM and registered
// level / press pulse / release pulse / press-toggle outputs.
// Ports:
//   CLOCK_50  system clock, rising edge
//   RESET     synchronous active-high reset
//   bus       key_conditioner_if.slave (KEY in, KEY_LEVEL/PRESS/RELEASE/TOGGLE out)
// Optional feature: define KEY_REPEAT_EN for auto-repeat press pulses while held.
module key_conditioner #(
    parameter int unsigned N_KEYS          = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_RATE     = 5000000
) (
    input  logic               CLOCK_50,
    input  logic               RESET,
    key_conditioner_if.slave   bus
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Reject configurations the debounce/repeat logic cannot represent.
    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_cfg
        $error("key_conditioner: DEBOUNCE_CYCLES must be >= 2, repeat periods >= 1");
    end

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } key_state_e;

    logic [N_KEYS-1:0] sync1_q, sync2_q;
    logic [N_KEYS-1:0] p_c;
    key_state_e        state_q [N_KEYS];
    key_state_e        state_d [N_KEYS];
    logic [CNT_W-1:0]  cnt_q   [N_KEYS];
    logic [CNT_W-1:0]  cnt_d   [N_KEYS];
    logic [N_KEYS-1:0] level_q, level_d;
    logic [N_KEYS-1:0] press_q, press_d;
    logic [N_KEYS-1:0] release_q, release_d;
    logic [N_KEYS-1:0] toggle_q, toggle_d;

`ifdef KEY_REPEAT_EN
    localparam int unsigned RPT_MAX  = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RPT_W    = ($clog2(RPT_MAX) < 1) ? 1 : $clog2(RPT_MAX);
    localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

    logic [RPT_W-1:0]  rpt_q [N_KEYS];
    logic [RPT_W-1:0]  rpt_d [N_KEYS];
    // 1 once the initial repeat delay has elapsed; later periods use REPEAT_RATE.
    logic [N_KEYS-1:0] rpt_run_q, rpt_run_d;
`endif

    // Second synchroniser flop, inverted: 1 = pressed.
    assign p_c = ~sync2_q;

    // Per-key debounce next-state and output pulses.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        toggle_d  = toggle_q;
`ifdef KEY_REPEAT_EN
        rpt_d     = rpt_q;
        rpt_run_d = rpt_run_q;
`endif
        for (int k = 0; k < int'(N_KEYS); k++) begin
            case (state_q[k])
                RELEASED: begin
                    if (p_c[k]) begin
                        state_d[k] = PRESS_WAIT;
                        cnt_d[k]   = '0;
                    end
                end
                PRESS_WAIT: begin
                    // A revert wins over the terminal count.
                    if (!p_c[k]) begin
                        state_d[k] = RELEASED;
                    end else if (cnt_q[k] == CNT_LAST) begin
                        state_d[k]  = PRESSED;
                        level_d[k]  = 1'b1;
                        press_d[k]  = 1'b1;
                        toggle_d[k] = ~toggle_q[k];
`ifdef KEY_REPEAT_EN
                        rpt_d[k]     = '0;
                        rpt_run_d[k] = 1'b0;
`endif
                    end else begin
                        cnt_d[k] = cnt_q[k] + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (!p_c[k]) begin
                        state_d[k] = RELEASE_WAIT;
                        cnt_d[k]   = '0;
`ifdef KEY_REPEAT_EN
                        rpt_d[k]     = '0;
                        rpt_run_d[k] = 1'b0;
                    end else if (rpt_q[k] == (rpt_run_q[k] ? RATE_LAST : DELAY_LAST)) begin
                        press_d[k]   = 1'b1;
                        rpt_d[k]     = '0;
                        rpt_run_d[k] = 1'b1;
                    end else begin
                        rpt_d[k] = rpt_q[k] + RPT_W'(1);
`endif
                    end
                end
                RELEASE_WAIT: begin
                    // Repeat counter stays cleared here, so a bounce back restarts it.
                    if (p_c[k]) begin
                        state_d[k] = PRESSED;
                    end else if (cnt_q[k] == CNT_LAST) begin
                        state_d[k]   = RELEASED;
                        level_d[k]   = 1'b0;
                        release_d[k] = 1'b1;
                    end else begin
                        cnt_d[k] = cnt_q[k] + CNT_W'(1);
                    end
                end
                default: begin
                    state_d[k] = RELEASED;
                end
            endcase
        end
    end

    // State, synchroniser and output registers.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            for (int k = 0; k < int'(N_KEYS); k++) begin
                state_q[k] <= RELEASED;
                cnt_q[k]   <= '0;
`ifdef KEY_REPEAT_EN
                rpt_q[k]   <= '0;
`endif
            end
`ifdef KEY_REPEAT_EN
            rpt_run_q <= '0;
`endif
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            toggle_q  <= '0;
        end else begin
            sync1_q   <= bus.KEY;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
`ifdef KEY_REPEAT_EN
            rpt_q     <= rpt_d;
            rpt_run_q <= rpt_run_d;
`endif
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            toggle_q  <= toggle_d;
        end
    end

    assign bus.KEY_LEVEL   = level_q;
    assign bus.KEY_PRESS   = press_q;
    assign bus.KEY_RELEASE = release_q;
    assign bus.KEY_TOGGLE  = toggle_q;

endmodule
